// File: rtl/alu_exec_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_ctrl_pkg
// Shared definitions for the ALU issue/write-back controller:
//   - ALUOP_* operation codes understood by the 8-bit ALU
//   - FSM state encoding (ST_IDLE / ST_EXEC)
//   - packed flag record {Z,S,C,OF}
// ---------------------------------------------------------------------------
package alu_exec_ctrl_pkg;

    localparam int ALUOP_W = 5;
    localparam int FLAGS_W = 4;

    // ALU operation codes
    localparam logic [ALUOP_W-1:0] ALUOP_PD1 = 5'd0;   // pass Data1, flags untouched
    localparam logic [ALUOP_W-1:0] ALUOP_PD2 = 5'd1;   // pass Data2, flags untouched
    localparam logic [ALUOP_W-1:0] ALUOP_ADD = 5'd2;
    localparam logic [ALUOP_W-1:0] ALUOP_ADC = 5'd3;   // add with ALU-internal carry
    localparam logic [ALUOP_W-1:0] ALUOP_SUB = 5'd4;   // C = borrow
    localparam logic [ALUOP_W-1:0] ALUOP_SBB = 5'd5;
    localparam logic [ALUOP_W-1:0] ALUOP_AND = 5'd6;
    localparam logic [ALUOP_W-1:0] ALUOP_OR  = 5'd7;
    localparam logic [ALUOP_W-1:0] ALUOP_XOR = 5'd8;
    localparam logic [ALUOP_W-1:0] ALUOP_NOT = 5'd9;   // flags untouched
    localparam logic [ALUOP_W-1:0] ALUOP_INC = 5'd10;
    localparam logic [ALUOP_W-1:0] ALUOP_DEC = 5'd11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    typedef struct packed {
        logic z;
        logic s;
        logic c;
        logic of;
    } flags_t;

    function automatic flags_t make_flags(input logic z, input logic s,
                                          input logic c, input logic of);
        flags_t f;
        f.z  = z;
        f.s  = s;
        f.c  = c;
        f.of = of;
        return f;
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_reg_file.sv
// ---------------------------------------------------------------------------
// reg_file_8x8
// Architectural register file for the issue controller.
//   clk        : write clock (posedge)
//   rst_n      : asynchronous, active-low clear of every entry
//   we/waddr/wdata : single synchronous write port
//   raddr_a/rdata_a, raddr_b/rdata_b : combinational operand read ports
//   dbg_addr/dbg_data : combinational debug read port
// Reads are combinational so a value written at one edge is seen by an
// operand fetch at the following edge without any bypass path.
// NREGS must equal 2**RW.
// ---------------------------------------------------------------------------
module reg_file_8x8 #(
    parameter int NREGS = 8,
    parameter int RW    = 3,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [RW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    input  logic [RW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] words [NREGS];

    // One register per entry, each with its own decoded write enable.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_word
            logic [DW-1:0] word_reg;
            logic          hit;

            assign hit = we && (waddr == RW'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (hit) begin
                    word_reg <= wdata;
                end
            end

            assign words[gi] = word_reg;
        end
    endgenerate

    assign rdata_a  = words[raddr_a];
    assign rdata_b  = words[raddr_b];
    assign dbg_data = words[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// ---------------------------------------------------------------------------
// alu_exec_ctrl
// Issue / write-back controller sitting between the instruction decoder and
// the 8-bit ALU. Accepts one instruction per handshake, fetches operands
// from the internal register file, drives the ALU for one cycle, then
// captures result and flags and writes the result back.
//
// Ports:
//   i_CLK, i_RST          clock (posedge) / async active-low reset
//   i_Valid, o_Ready      instruction handshake (o_Ready high only in IDLE)
//   i_Op, i_Rd, i_Rs, i_Imm, i_UseImm, i_NoWB   instruction fields
//   o_Data1, o_Data2, o_ALUOp                   ALU operand/op drive
//   i_Result, i_Z, i_S, i_C, i_OF               ALU result/flags
//   o_Flags {Z,S,C,OF}, o_Done, o_WBData        completion outputs
//   i_DbgAddr, o_DbgData                        debug register read
//
// Timing: accept at edge N, ALU evaluates on the following negedge,
// completion (o_Done, flags, write-back) at edge N+1, next accept at N+2.
// ---------------------------------------------------------------------------
module alu_exec_ctrl
    import alu_exec_ctrl_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int RW    = 3,
    parameter int DW    = 8
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    input  logic               i_Valid,
    output logic               o_Ready,
    input  logic [ALUOP_W-1:0] i_Op,
    input  logic [RW-1:0]      i_Rd,
    input  logic [RW-1:0]      i_Rs,
    input  logic [DW-1:0]      i_Imm,
    input  logic               i_UseImm,
    input  logic               i_NoWB,
    output logic [DW-1:0]      o_Data1,
    output logic [DW-1:0]      o_Data2,
    output logic [ALUOP_W-1:0] o_ALUOp,
    input  logic [DW-1:0]      i_Result,
    input  logic               i_Z,
    input  logic               i_S,
    input  logic               i_C,
    input  logic               i_OF,
    output logic [FLAGS_W-1:0] o_Flags,
    output logic               o_Done,
    output logic [DW-1:0]      o_WBData,
    input  logic [RW-1:0]      i_DbgAddr,
    output logic [DW-1:0]      o_DbgData
);

    state_t               state_reg,  state_next;
    logic [DW-1:0]        data1_reg,  data1_next;
    logic [DW-1:0]        data2_reg,  data2_next;
    logic [ALUOP_W-1:0]   aluop_reg,  aluop_next;
    logic [RW-1:0]        rd_reg,     rd_next;
    logic                 nowb_reg,   nowb_next;
    flags_t               flags_reg,  flags_next;
    logic                 done_reg,   done_next;
    logic [DW-1:0]        wbdata_reg, wbdata_next;

    logic [DW-1:0]        rd_data;
    logic [DW-1:0]        rs_data;
    logic                 rf_we;

    reg_file_8x8 #(
        .NREGS (NREGS),
        .RW    (RW),
        .DW    (DW)
    ) u_rf (
        .clk      (i_CLK),
        .rst_n    (i_RST),
        .we       (rf_we),
        .waddr    (rd_reg),
        .wdata    (i_Result),
        .raddr_a  (i_Rd),
        .rdata_a  (rd_data),
        .raddr_b  (i_Rs),
        .rdata_b  (rs_data),
        .dbg_addr (i_DbgAddr),
        .dbg_data (o_DbgData)
    );

    // State register
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_next  = state_reg;
        data1_next  = data1_reg;
        data2_next  = data2_reg;
        aluop_next  = aluop_reg;
        rd_next     = rd_reg;
        nowb_next   = nowb_reg;
        flags_next  = flags_reg;
        wbdata_next = wbdata_reg;
        done_next   = 1'b0;
        rf_we       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // PD1 leaves the ALU flags alone while nothing is in flight.
                aluop_next = ALUOP_PD1;
                if (i_Valid) begin
                    data1_next = rd_data;
                    data2_next = i_UseImm ? i_Imm : rs_data;
                    aluop_next = i_Op;
                    rd_next    = i_Rd;
                    nowb_next  = i_NoWB;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // ALU settled on the negedge inside this cycle; retire now.
                flags_next  = make_flags(i_Z, i_S, i_C, i_OF);
                wbdata_next = i_Result;
                rf_we       = !nowb_reg;
                done_next   = 1'b1;
                aluop_next  = ALUOP_PD1;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            data1_reg  <= '0;
            data2_reg  <= '0;
            aluop_reg  <= ALUOP_PD1;
            rd_reg     <= '0;
            nowb_reg   <= 1'b0;
            flags_reg  <= '0;
            done_reg   <= 1'b0;
            wbdata_reg <= '0;
        end else begin
            data1_reg  <= data1_next;
            data2_reg  <= data2_next;
            aluop_reg  <= aluop_next;
            rd_reg     <= rd_next;
            nowb_reg   <= nowb_next;
            flags_reg  <= flags_next;
            done_reg   <= done_next;
            wbdata_reg <= wbdata_next;
        end
    end

    assign o_Ready  = (state_reg == ST_IDLE);
    assign o_Data1  = data1_reg;
    assign o_Data2  = data2_reg;
    assign o_ALUOp  = aluop_reg;
    assign o_Flags  = flags_reg;
    assign o_Done   = done_reg;
    assign o_WBData = wbdata_reg;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_ctrl
// Bench for alu_exec_ctrl with a behavioural negedge ALU. Table-driven
// instruction vectors with a scoreboard queue, plus hand-written sequences
// for back-to-back issue, reset during EXEC and idle flag preservation.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_exec_ctrl;
    import alu_exec_ctrl_pkg::*;

    logic       i_CLK = 1'b0;
    logic       i_RST = 1'b0;
    logic       i_Valid = 1'b0;
    logic       o_Ready;
    logic [4:0] i_Op = ALUOP_PD1;
    logic [2:0] i_Rd = '0;
    logic [2:0] i_Rs = '0;
    logic [7:0] i_Imm = '0;
    logic       i_UseImm = 1'b0;
    logic       i_NoWB = 1'b0;
    logic [7:0] o_Data1, o_Data2;
    logic [4:0] o_ALUOp;
    logic [7:0] alu_res = '0;
    logic       az = 1'b0, as_f = 1'b0, ac = 1'b0, aof = 1'b0;
    logic [3:0] o_Flags;
    logic       o_Done;
    logic [7:0] o_WBData;
    logic [2:0] i_DbgAddr = '0;
    logic [7:0] o_DbgData;

    int total = 0;
    int bad = 0;
    int pushed = 0;
    int done_seen = 0;

    typedef struct {
        logic [4:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [7:0] imm;
        logic       useimm;
        logic       nowb;
        logic [7:0] exp_wb;
        logic [3:0] exp_flags;
        logic [7:0] exp_rf;
    } vec_t;

    vec_t tbl [12];
    vec_t sb [$];

    alu_exec_ctrl #(.NREGS(8), .RW(3), .DW(8)) dut (
        .i_CLK     (i_CLK),
        .i_RST     (i_RST),
        .i_Valid   (i_Valid),
        .o_Ready   (o_Ready),
        .i_Op      (i_Op),
        .i_Rd      (i_Rd),
        .i_Rs      (i_Rs),
        .i_Imm     (i_Imm),
        .i_UseImm  (i_UseImm),
        .i_NoWB    (i_NoWB),
        .o_Data1   (o_Data1),
        .o_Data2   (o_Data2),
        .o_ALUOp   (o_ALUOp),
        .i_Result  (alu_res),
        .i_Z       (az),
        .i_S       (as_f),
        .i_C       (ac),
        .i_OF      (aof),
        .o_Flags   (o_Flags),
        .o_Done    (o_Done),
        .o_WBData  (o_WBData),
        .i_DbgAddr (i_DbgAddr),
        .o_DbgData (o_DbgData)
    );

    always #5 i_CLK = ~i_CLK;

    // Behavioural ALU: evaluates on negedge, keeps its own flags.
    always @(negedge i_CLK) begin : alu_model
        logic [8:0] w;
        logic [7:0] a, b, r;
        logic       nc, nof, upd;
        a = o_Data1; b = o_Data2; r = a; w = '0;
        nc = ac; nof = aof; upd = 1'b1;
        case (o_ALUOp)
            ALUOP_PD1: begin r = a; upd = 1'b0; end
            ALUOP_PD2: begin r = b; upd = 1'b0; end
            ALUOP_NOT: begin r = ~a; upd = 1'b0; end
            ALUOP_ADD: begin
                w = {1'b0, a} + {1'b0, b}; r = w[7:0]; nc = w[8];
                nof = (a[7] == b[7]) && (r[7] != a[7]);
            end
            ALUOP_ADC: begin
                w = {1'b0, a} + {1'b0, b} + {8'd0, ac}; r = w[7:0]; nc = w[8];
                nof = (a[7] == b[7]) && (r[7] != a[7]);
            end
            ALUOP_SUB: begin
                w = {1'b0, a} - {1'b0, b}; r = w[7:0]; nc = w[8];
                nof = (a[7] != b[7]) && (r[7] != a[7]);
            end
            ALUOP_AND: begin r = a & b; nc = 1'b0; nof = 1'b0; end
            ALUOP_OR:  begin r = a | b; nc = 1'b0; nof = 1'b0; end
            ALUOP_XOR: begin r = a ^ b; nc = 1'b0; nof = 1'b0; end
            ALUOP_INC: begin
                w = {1'b0, a} + 9'd1; r = w[7:0]; nc = w[8]; nof = (a == 8'h7F);
            end
            ALUOP_DEC: begin
                w = {1'b0, a} - 9'd1; r = w[7:0]; nc = w[8]; nof = (a == 8'h80);
            end
            default: upd = 1'b0;
        endcase
        alu_res <= r;
        if (upd) begin
            az   <= (r == 8'h00);
            as_f <= r[7];
            ac   <= nc;
            aof  <= nof;
        end
    end

    // Independent count of completion pulses, compared against pushes.
    always @(posedge i_CLK) begin
        #1;
        if (o_Done) done_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic drive(input vec_t v);
        i_Op = v.op; i_Rd = v.rd; i_Rs = v.rs; i_Imm = v.imm;
        i_UseImm = v.useimm; i_NoWB = v.nowb; i_Valid = 1'b1;
    endtask

    // Pop the oldest expectation and compare against the completing result.
    task automatic pop_cmp();
        vec_t e;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("wbdata", 32'(o_WBData), 32'(e.exp_wb));
        chk("flags", 32'(o_Flags), 32'(e.exp_flags));
        i_DbgAddr = e.rd;
        #1;
        chk("rf_rd", 32'(o_DbgData), 32'(e.exp_rf));
    endtask

    // Issue one instruction from idle and wait (bounded) for completion.
    task automatic issue(input vec_t v);
        int lat;
        drive(v);
        chk("ready_before", 32'(o_Ready), 32'd1);
        @(posedge i_CLK); #1;
        i_Valid = 1'b0;
        sb.push_back(v); pushed++;
        chk("ready_exec", 32'(o_Ready), 32'd0);
        lat = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge i_CLK); #1;
            if (o_Done) begin lat = k; break; end
        end
        chk("latency", 32'(lat), 32'd1);
        if (lat != 0) begin
            chk("ready_after", 32'(o_Ready), 32'd1);
            pop_cmp();
        end
    endtask

    initial begin
        vec_t v;
        //         op         rd    rs    imm    ui    nowb  wb     ZSCO     rf
        tbl[0]  = '{ALUOP_PD2, 3'd1, 3'd0, 8'h7F, 1'b1, 1'b0, 8'h7F, 4'b0000, 8'h7F};
        tbl[1]  = '{ALUOP_ADD, 3'd1, 3'd0, 8'h01, 1'b1, 1'b0, 8'h80, 4'b0101, 8'h80};
        tbl[2]  = '{ALUOP_SUB, 3'd1, 3'd0, 8'h80, 1'b1, 1'b1, 8'h00, 4'b1000, 8'h80};
        tbl[3]  = '{ALUOP_PD2, 3'd2, 3'd0, 8'hFF, 1'b1, 1'b0, 8'hFF, 4'b1000, 8'hFF};
        tbl[4]  = '{ALUOP_PD2, 3'd3, 3'd0, 8'h05, 1'b1, 1'b0, 8'h05, 4'b1000, 8'h05};
        tbl[5]  = '{ALUOP_PD2, 3'd4, 3'd0, 8'h3C, 1'b1, 1'b0, 8'h3C, 4'b1000, 8'h3C};
        tbl[6]  = '{ALUOP_XOR, 3'd4, 3'd3, 8'hAA, 1'b0, 1'b0, 8'h39, 4'b0000, 8'h39};
        tbl[7]  = '{ALUOP_NOT, 3'd4, 3'd0, 8'h00, 1'b0, 1'b0, 8'hC6, 4'b0000, 8'hC6};
        tbl[8]  = '{ALUOP_DEC, 3'd5, 3'd0, 8'h00, 1'b0, 1'b0, 8'hFF, 4'b0110, 8'hFF};
        tbl[9]  = '{ALUOP_ADC, 3'd5, 3'd0, 8'h01, 1'b1, 1'b0, 8'h01, 4'b0010, 8'h01};
        tbl[10] = '{ALUOP_SUB, 3'd6, 3'd6, 8'h00, 1'b0, 1'b0, 8'h00, 4'b1000, 8'h00};
        tbl[11] = '{ALUOP_OR,  3'd1, 3'd5, 8'h00, 1'b0, 1'b0, 8'h81, 4'b0100, 8'h81};

        // Reset state
        #12;
        chk("rst_ready", 32'(o_Ready), 32'd1);
        chk("rst_done", 32'(o_Done), 32'd0);
        chk("rst_aluop", 32'(o_ALUOp), 32'(ALUOP_PD1));
        chk("rst_flags", 32'(o_Flags), 32'd0);
        chk("rst_wbdata", 32'(o_WBData), 32'd0);
        chk("rst_data", 32'({o_Data1, o_Data2}), 32'd0);
        i_RST = 1'b1;
        @(posedge i_CLK); #1;

        for (int i = 0; i < 12; i++) issue(tbl[i]);

        // Back-to-back with i_Valid held high; fields changed during EXEC
        // must be ignored and the second accept lands two edges later.
        v = '{ALUOP_INC, 3'd2, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b1010, 8'h00};
        drive(v);
        @(posedge i_CLK); #1;
        sb.push_back(v); pushed++;
        chk("b2b_ready_exec", 32'(o_Ready), 32'd0);
        v = '{ALUOP_ADD, 3'd3, 3'd2, 8'h00, 1'b0, 1'b0, 8'h05, 4'b0000, 8'h05};
        drive(v);
        @(posedge i_CLK); #1;
        chk("b2b_done1", 32'(o_Done), 32'd1);
        chk("b2b_ready_idle", 32'(o_Ready), 32'd1);
        pop_cmp();
        @(posedge i_CLK); #1;
        sb.push_back(v); pushed++;
        i_Valid = 1'b0;
        chk("b2b_accept2", 32'({o_Ready, o_Done}), 32'd0);
        @(posedge i_CLK); #1;
        chk("b2b_done2", 32'(o_Done), 32'd1);
        pop_cmp();

        // Reset pulse during EXEC of ADD Rd=4
        v = '{ALUOP_ADD, 3'd4, 3'd0, 8'h01, 1'b1, 1'b0, 8'h00, 4'b0000, 8'h00};
        drive(v);
        @(posedge i_CLK); #1;
        i_Valid = 1'b0;
        chk("rexec_ready", 32'(o_Ready), 32'd0);
        #5 i_RST = 1'b0;
        #1 i_RST = 1'b1;
        @(posedge i_CLK); #1;
        chk("rexec_no_done", 32'(o_Done), 32'd0);
        chk("rexec_ready", 32'(o_Ready), 32'd1);
        chk("rexec_aluop", 32'(o_ALUOp), 32'(ALUOP_PD1));
        chk("rexec_flags_wb", 32'({o_Flags, o_WBData}), 32'd0);
        for (int a = 0; a < 8; a++) begin
            i_DbgAddr = 3'(a);
            #1;
            chk($sformatf("rexec_rf%0d", a), 32'(o_DbgData), 32'd0);
        end

        // Idle flag preservation
        issue('{ALUOP_SUB, 3'd0, 3'd0, 8'h00, 1'b1, 1'b1, 8'h00, 4'b1000, 8'h00});
        for (int c = 0; c < 10; c++) begin
            @(posedge i_CLK); #1;
            chk("idle_aluop", 32'(o_ALUOp), 32'(ALUOP_PD1));
            chk("idle_flags", 32'(o_Flags), 32'b1000);
        end
        issue('{ALUOP_PD2, 3'd7, 3'd0, 8'h5A, 1'b1, 1'b0, 8'h5A, 4'b1000, 8'h5A});

        @(posedge i_CLK); #2;
        chk("done_count", 32'(done_seen), 32'(pushed));
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
